// File: rtl/jk_cnt_pkg.sv
// Shared definitions for the JK-cell down counter.
//   cnt_state_e  : control FSM states (RUN counts, HALT holds at zero)
//   CNT_WIDTH    : default count width
//   CNT_ALL_ONES : preset value of the count register at the default width
package jk_cnt_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } cnt_state_e;

    localparam int                    CNT_WIDTH    = 6;
    localparam logic [CNT_WIDTH-1:0]  CNT_ALL_ONES = '1;

endpackage

// File: rtl/jk_down_counter6_if.sv
// Control/status bundle for jk_down_counter6.
//   master: drives en, load, din, stop_mode; observes q, zero, tc, halted
//   slave : the counter itself
interface jk_down_counter6_if
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             stop_mode;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;
    logic             halted;

    modport master (
        output en, load, din, stop_mode,
        input  q, zero, tc, halted
    );

    modport slave (
        input  en, load, din, stop_mode,
        output q, zero, tc, halted
    );
endinterface

// File: rtl/jk_ff_pc.sv
// Single JK flip-flop with asynchronous active-high preset and clear.
//   q, qn : true / complement outputs
//   j, k  : 00 hold, 01 reset, 10 set, 11 toggle on posedge clk
//   pre   : async set to 1
//   clr   : async clear to 0, wins over pre
module jk_ff_pc (
    output logic q,
    output logic qn,
    input  logic j,
    input  logic k,
    input  logic clk,
    input  logic pre,
    input  logic clr
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b00: q_d = q_q;
            2'b01: q_d = 1'b0;
            2'b10: q_d = 1'b1;
            2'b11: q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr or posedge pre) begin
        if (clr)
            q_q <= 1'b0;
        else if (pre)
            q_q <= 1'b1;
        else
            q_q <= q_d;
    end

    assign q  = q_q;
    assign qn = ~q_q;
endmodule

// File: rtl/jk_down_counter6.sv
// Loadable down counter built from JK cells, with wrap or stop-at-zero modes.
//   clk    : posedge clock
//   preset : async active-high; count -> all ones, FSM -> RUN, tc -> 0
//   bus    : slave side of jk_down_counter6_if
//            en/load/din/stop_mode in; q/zero/tc/halted out
module jk_down_counter6
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic                clk,
    input  logic                preset,
    jk_down_counter6_if.slave   bus
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_qn;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH:0]   lo_zero;

    cnt_state_e state_q, state_d;
    logic       tc_q, tc_d;

    logic at_zero;
    logic at_one;
    logic en_eff;
    logic dec;

    // lo_zero[i] is high when every bit below i is zero: bit i toggles on a
    // decrement exactly when all lower bits would borrow.
    always_comb begin
        lo_zero[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++)
            lo_zero[i+1] = lo_zero[i] & cnt_qn[i];
    end

    assign at_zero = lo_zero[WIDTH];
    assign at_one  = (cnt_q == WIDTH'(1));
    assign en_eff  = bus.en & (state_q == RUN) & ~bus.load;
    // A zero count in stop mode must not wrap; the FSM parks in HALT instead.
    assign dec     = en_eff & ~(bus.stop_mode & at_zero);

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.load) begin
                j[i] = bus.din[i];
                k[i] = ~bus.din[i];
            end else begin
                j[i] = dec & lo_zero[i];
                k[i] = dec & lo_zero[i];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_pc u_ff (
            .q   (cnt_q[i]),
            .qn  (cnt_qn[i]),
            .j   (j[i]),
            .k   (k[i]),
            .clk (clk),
            .pre (preset),
            .clr (1'b0)
        );
    end

    always_comb begin
        state_d = state_q;
        tc_d    = dec & at_one;
        case (state_q)
            RUN: begin
                // Covers both the 1->0 step and a loaded zero.
                if (en_eff && bus.stop_mode && (at_one || at_zero))
                    state_d = HALT;
            end
            HALT: begin
                if (bus.load && (bus.din != '0))
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q <= RUN;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.q      = cnt_q;
    assign bus.zero   = at_zero;
    assign bus.tc     = tc_q;
    assign bus.halted = (state_q == HALT);
endmodule

// File: tb/tb_jk_down_counter6.sv
module tb_jk_down_counter6;
    localparam int W = 6;

    typedef struct {
        logic         en;
        logic         load;
        logic [W-1:0] din;
        logic         sm;
        logic [W-1:0] eq;
        logic         etc;
        logic         eh;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic         tc;
        logic         h;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic preset;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    exp_t sb[$];

    jk_down_counter6_if #(.WIDTH(W)) bus ();

    jk_down_counter6 #(.WIDTH(W)) dut (
        .clk    (clk),
        .preset (preset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [W-1:0] eq,
                             input logic etc, input logic eh);
        chk({name, ".q"},      16'(bus.q), 16'(eq));
        chk({name, ".zero"},   16'(bus.zero), 16'(eq == '0));
        chk({name, ".tc"},     16'(bus.tc), 16'(etc));
        chk({name, ".halted"}, 16'(bus.halted), 16'(eh));
    endtask

    // Called at posedge+1: drive, queue expectation, take one edge, compare.
    task automatic step(input string name, input logic en, input logic ld,
                        input logic [W-1:0] din, input logic sm,
                        input logic [W-1:0] eq, input logic etc, input logic eh);
        exp_t e;
        bus.en = en; bus.load = ld; bus.din = din; bus.stop_mode = sm;
        e.q = eq; e.tc = etc; e.h = eh; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check_out(e.name, e.q, e.tc, e.h);
        end
    endtask

    function automatic void add(input logic en, input logic ld, input int din,
                                input logic sm, input int eq, input logic etc,
                                input logic eh);
        vec_t v;
        v.en = en; v.load = ld; v.din = W'(din); v.sm = sm;
        v.eq = W'(eq); v.etc = etc; v.eh = eh;
        tbl.push_back(v);
    endfunction

    initial begin
        // wrap: load 2 then 1, 0, 63, 62
        add(0,1, 2,0,  2,0,0);
        add(1,0, 0,0,  1,0,0);
        add(1,0, 0,0,  0,1,0);
        add(1,0, 0,0, 63,0,0);
        add(1,0, 0,0, 62,0,0);
        // stop: load 3 then 2, 1, 0 (halt) and hold
        add(0,1, 3,1,  3,0,0);
        add(1,0, 0,1,  2,0,0);
        add(1,0, 0,1,  1,0,0);
        add(1,0, 0,1,  0,1,1);
        add(1,0, 0,1,  0,0,1);
        add(1,0, 0,1,  0,0,1);
        // restart from halt, then halt again, load 0 and stop_mode clear stay halted
        add(1,1, 5,1,  5,0,0);
        add(1,0, 0,1,  4,0,0);
        add(0,1, 1,1,  1,0,0);
        add(1,0, 0,1,  0,1,1);
        add(0,1, 0,1,  0,0,1);
        add(1,0, 0,0,  0,0,1);
        add(1,0, 0,0,  0,0,1);
        // priority: load beats decrement at q == 1
        add(0,1, 1,0,  1,0,0);
        add(1,1,40,0, 40,0,0);
        add(0,0, 0,0, 40,0,0);
        add(0,0, 0,0, 40,0,0);
        add(0,0, 0,0, 40,0,0);
        add(1,0, 0,0, 39,0,0);
        // loaded zero in stop mode: halt on next enabled edge, no tc
        add(0,1, 0,1,  0,0,0);
        add(1,0, 0,1,  0,0,1);
        add(0,0, 0,1,  0,0,1);

        preset = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.din = '0; bus.stop_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 6'd63, 1'b0, 1'b0);
        preset = 1'b0;

        step("pre_cnt0", 1,0,0,0, 62,0,0);
        step("pre_cnt1", 1,0,0,0, 61,0,0);
        step("pre_cnt2", 1,0,0,0, 60,0,0);

        // mid-cycle preset with en high takes effect without a clock edge
        #3 preset = 1'b1;
        #1;
        check_out("async_preset", 6'd63, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("preset_hold", 6'd63, 1'b0, 1'b0);
        preset = 1'b0;

        for (int i = 1; i <= 63; i++)
            step($sformatf("run63_%0d", i), 1,0,0,0, W'(63 - i), (i == 63), 0);
        step("tc_clear", 0,0,0,0, 0,0,0);

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].en, tbl[i].load, tbl[i].din,
                 tbl[i].sm, tbl[i].eq, tbl[i].etc, tbl[i].eh);

        // preset while halted returns to RUN at all ones
        #3 preset = 1'b1;
        #1;
        check_out("halt_preset", 6'd63, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        preset = 1'b0;
        step("post_halt0", 1,0,0,1, 62,0,0);
        step("post_halt1", 1,0,0,1, 61,0,0);

        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
